// File: rtl/seven_segment_decoder.sv
// Registered BCD-to-seven-segment decoder with lamp-test, blanking and
// ripple-blanking controls for leading-zero suppression across digits.
module seven_segment_decoder #(
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit HEX_MODE       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic lt_n,
    input  logic bi_n,
    input  logic rbi_n,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic rbo_n
);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ALL   = 7'b1111111;

    logic [3:0] code;
    logic [6:0] glyph;
    logic [6:0] seg_next;
    logic       rbo_next;
    logic [6:0] seg_q;
    logic       rbo_q;

    assign code = {A, B, C, D};

    // Glyph lookup in lit-is-1 form (segment order abcdefg); polarity comes later.
    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'd0:  glyph = 7'b1111110;
            4'd1:  glyph = 7'b0110000;
            4'd2:  glyph = 7'b1101101;
            4'd3:  glyph = 7'b1111001;
            4'd4:  glyph = 7'b0110011;
            4'd5:  glyph = 7'b1011011;
            4'd6:  glyph = 7'b1011111;
            4'd7:  glyph = 7'b1110000;
            4'd8:  glyph = 7'b1111111;
            4'd9:  glyph = 7'b1111011;
            4'd10: glyph = HEX_MODE ? 7'b1110111 : SEG_BLANK;
            4'd11: glyph = HEX_MODE ? 7'b0011111 : SEG_BLANK;
            4'd12: glyph = HEX_MODE ? 7'b1001110 : SEG_BLANK;
            4'd13: glyph = HEX_MODE ? 7'b0111101 : SEG_BLANK;
            4'd14: glyph = HEX_MODE ? 7'b1001111 : SEG_BLANK;
            4'd15: glyph = HEX_MODE ? 7'b1000111 : SEG_BLANK;
            default: glyph = SEG_BLANK;
        endcase
    end

    // Control priority: blanking, then lamp test, then zero suppression.
    always_comb begin
        seg_next = glyph;
        rbo_next = 1'b1;
        if (!bi_n) begin
            seg_next = SEG_BLANK;
        end else if (!lt_n) begin
            seg_next = SEG_ALL;
        end else if (!rbi_n && (code == 4'd0)) begin
            seg_next = SEG_BLANK;
            rbo_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK ^ {7{SEG_ACTIVE_LOW}};
            rbo_q <= 1'b1;
        end else begin
            seg_q <= seg_next ^ {7{SEG_ACTIVE_LOW}};
            rbo_q <= rbo_next;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign rbo_n = rbo_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed self-checking bench for seven_segment_decoder; three instances
// cover the default, common-anode and hex-glyph parameter variants.
module tb_seven_segment_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] code;
    logic lt_n, bi_n, rbi_n;

    logic [6:0] seg0, seg1, seg2;
    logic       rbo0, rbo1, rbo2;

    int checks = 0;
    int failures = 0;

    logic [6:0] digit_pat [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    always #5 clk = ~clk;

    seven_segment_decoder #(.SEG_ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .A(code[3]), .B(code[2]), .C(code[1]), .D(code[0]),
        .lt_n(lt_n), .bi_n(bi_n), .rbi_n(rbi_n),
        .a(seg0[6]), .b(seg0[5]), .c(seg0[4]), .d(seg0[3]),
        .e(seg0[2]), .f(seg0[1]), .g(seg0[0]), .rbo_n(rbo0)
    );

    seven_segment_decoder #(.SEG_ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .A(code[3]), .B(code[2]), .C(code[1]), .D(code[0]),
        .lt_n(lt_n), .bi_n(bi_n), .rbi_n(rbi_n),
        .a(seg1[6]), .b(seg1[5]), .c(seg1[4]), .d(seg1[3]),
        .e(seg1[2]), .f(seg1[1]), .g(seg1[0]), .rbo_n(rbo1)
    );

    seven_segment_decoder #(.SEG_ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .A(code[3]), .B(code[2]), .C(code[1]), .D(code[0]),
        .lt_n(lt_n), .bi_n(bi_n), .rbi_n(rbi_n),
        .a(seg2[6]), .b(seg2[5]), .c(seg2[4]), .d(seg2[3]),
        .e(seg2[2]), .f(seg2[1]), .g(seg2[0]), .rbo_n(rbo2)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns after the next rising edge.
    task automatic apply_stimulus(input logic [3:0] c_in, input logic lt_in,
                                  input logic bi_in, input logic rbi_in);
        @(negedge clk);
        code  = c_in;
        lt_n  = lt_in;
        bi_n  = bi_in;
        rbi_n = rbi_in;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed seg/rbo=%b required=%b", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        code  = 4'b1111;
        lt_n  = 1'b1;
        bi_n  = 1'b1;
        rbi_n = 1'b1;

        #1 rst_n = 1'b0;
        #2;
        check_output("reset_dut0", {seg0, rbo0}, 8'b0000000_1);
        check_output("reset_active_low", {seg1, rbo1}, 8'b1111111_1);
        check_output("reset_hex", {seg2, rbo2}, 8'b0000000_1);

        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(4'd15, 1'b1, 1'b1, 1'b1);
        check_output("code15_blank", {seg0, rbo0}, 8'b0000000_1);
        check_output("hex_F", {seg2, rbo2}, 8'b1000111_1);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(4'(i), 1'b1, 1'b1, 1'b1);
            check_output($sformatf("digit_%0d", i), {seg0, rbo0}, {digit_pat[i], 1'b1});
        end

        apply_stimulus(4'd1, 1'b0, 1'b1, 1'b1);
        check_output("lamp_test", {seg0, rbo0}, 8'b1111111_1);
        apply_stimulus(4'd1, 1'b0, 1'b0, 1'b1);
        check_output("blank_over_lt", {seg0, rbo0}, 8'b0000000_1);
        check_output("blank_active_low", {seg1, rbo1}, 8'b1111111_1);
        apply_stimulus(4'd1, 1'b1, 1'b1, 1'b1);
        check_output("release_ctrl", {seg0, rbo0}, 8'b0110000_1);

        apply_stimulus(4'd0, 1'b1, 1'b1, 1'b0);
        check_output("rbi_zero", {seg0, rbo0}, 8'b0000000_0);
        check_output("rbi_zero_active_low", {seg1, rbo1}, 8'b1111111_0);
        apply_stimulus(4'd5, 1'b1, 1'b1, 1'b0);
        check_output("rbi_five", {seg0, rbo0}, 8'b1011011_1);
        apply_stimulus(4'd0, 1'b1, 1'b1, 1'b1);
        check_output("no_rbi_zero", {seg0, rbo0}, 8'b1111110_1);
        apply_stimulus(4'd0, 1'b0, 1'b1, 1'b0);
        check_output("lt_over_rbi", {seg0, rbo0}, 8'b1111111_1);
        apply_stimulus(4'd0, 1'b1, 1'b0, 1'b0);
        check_output("bi_over_rbi", {seg0, rbo0}, 8'b0000000_1);
        apply_stimulus(4'd10, 1'b1, 1'b1, 1'b0);
        check_output("code10_rbi", {seg0, rbo0}, 8'b0000000_1);
        check_output("hex_A_rbi", {seg2, rbo2}, 8'b1110111_1);

        apply_stimulus(4'd11, 1'b1, 1'b1, 1'b1);
        check_output("hex_b", {seg2, rbo2}, 8'b0011111_1);
        apply_stimulus(4'd12, 1'b1, 1'b1, 1'b1);
        check_output("hex_C", {seg2, rbo2}, 8'b1001110_1);
        apply_stimulus(4'd13, 1'b1, 1'b1, 1'b1);
        check_output("hex_d", {seg2, rbo2}, 8'b0111101_1);
        apply_stimulus(4'd14, 1'b1, 1'b1, 1'b1);
        check_output("hex_E", {seg2, rbo2}, 8'b1001111_1);
        check_output("code14_active_low", {seg1, rbo1}, 8'b1111111_1);

        apply_stimulus(4'd8, 1'b1, 1'b1, 1'b1);
        check_output("eight", {seg0, rbo0}, 8'b1111111_1);
        check_output("eight_active_low", {seg1, rbo1}, 8'b0000000_1);
        check_output("eight_hex", {seg2, rbo2}, 8'b1111111_1);

        // Reset pulse falls between rising edges, so only the async path can clear outputs.
        #1 rst_n = 1'b0;
        #1;
        check_output("async_reset", {seg0, rbo0}, 8'b0000000_1);
        check_output("async_reset_active_low", {seg1, rbo1}, 8'b1111111_1);
        #1 rst_n = 1'b1;
        #1;
        check_output("held_after_reset", {seg0, rbo0}, 8'b0000000_1);
        apply_stimulus(4'd8, 1'b1, 1'b1, 1'b1);
        check_output("recover_eight", {seg0, rbo0}, 8'b1111111_1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

Registered BCD-to-seven-segment decoder for a single display digit. It converts a 4-bit BCD code on `A` (MSB), `B`, `C` and `D` (LSB) into the seven segment drives `a`–`g`. It adds lamp-test, blanking and ripple-blanking controls for multi-digit leading-zero suppression. It sits between the digit-value logic and the display pins, and all its outputs are registered.

## Interface
- `SEG_ACTIVE_LOW`, default 0: 0 means a lit segment is 1 (common cathode); 1 means a lit segment is 0 (common anode). Affects `a`–`g` only.
- `HEX_MODE`, default 0: 0 blanks codes 10–15; 1 displays them as hex glyphs A b C d E F.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `A`  in  1  code bit 3 (MSB).
- `B`  in  1  code bit 2.
- `C`  in  1  code bit 1.
- `D`  in  1  code bit 0 (LSB).
- `lt_n`  in  1  lamp test, active-low.
- `bi_n`  in  1  blanking input, active-low.
- `rbi_n`  in  1  ripple-blank input, active-low.
- `a`, `b`, `c`, `d`, `e`, `f`, `g`  out  1 each  segment drives, registered.
- `rbo_n`  out  1  ripple-blank output, active-low, registered.

## Operation
- The code is {A,B,C,D}, range 0–15.
- Segment patterns are listed as abcdefg, 1 = lit, before polarity is applied:
  - Digit 0: 1111110.
  - Digit 1: 0110000.
  - Digit 2: 1101101.
  - Digit 3: 1111001.
  - Digit 4: 0110011.
  - Digit 5: 1011011.
  - Digit 6: 1011111 (with top tail).
  - Digit 7: 1110000.
  - Digit 8: 1111111.
  - Digit 9: 1111011 (with bottom tail).
- Codes 10–15 depend on `HEX_MODE`:
  - With `HEX_MODE`=0: blank, 0000000.
  - With `HEX_MODE`=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Control priority, highest first:
  1. `bi_n`=0: all segments off, `rbo_n`=1.
  2. `lt_n`=0: all segments lit (1111111), `rbo_n`=1.
  3. `rbi_n`=0 and code=0: all segments off and `rbo_n`=0 (zero suppressed).
  4. Otherwise: decoded pattern, `rbo_n`=1.
- `rbo_n` is 0 only in case 3.
- Polarity is applied last. When `SEG_ACTIVE_LOW`=1, each of `a`–`g` is the inverse of the pattern above. This includes blank, which becomes all 1s.
- Multi-digit chaining: connect each digit's `rbo_n` to the `rbi_n` of the next less-significant digit. Tie the most-significant digit's `rbi_n` low and the units digit's `rbi_n` high.

## Timing
- All inputs except `rst_n` are sampled on the rising edge of `clk`.
- Outputs update on that same edge, giving one cycle of latency from input to output.
- No combinational path exists from any input to any output.
- Reset:
  - While `rst_n`=0, and immediately on its assertion with no clock needed: all segments are off (0 when `SEG_ACTIVE_LOW`=0, 1 when `SEG_ACTIVE_LOW`=1) and `rbo_n`=1.
  - The first decode after `rst_n` rises happens on the next rising edge.
  - Reset asserted mid-operation overrides the registers at once.
- Simultaneous control inputs resolve strictly by the priority list, with no cross-coupling between them.
- Codes 10–15 with `HEX_MODE`=0 are treated as non-zero: they blank the display but leave `rbo_n`=1.
- The input code is held in no state beyond the output register. A change is reflected exactly one edge later.

## Test plan
- Reset and invalid code: hold `rst_n`=0 with {A,B,C,D}=1111 → a–g=0000000 and `rbo_n`=1 with no clock. Release reset, keep `lt_n`=`bi_n`=`rbi_n`=1, clock once → a–g still 0000000 (code 15 blank, `HEX_MODE`=0).
- Digit sweep: apply codes 0–9 on successive edges → each pattern in the table appears exactly one edge later, e.g. 0000 → 1111110 and 0111 → 1110000.
- Controls:
  - `lt_n`=0 with code 0001 → 1111111.
  - Then also `bi_n`=0 → 0000000 (blanking wins).
  - Release both → 0110000 on the next edge.
- Ripple blanking:
  - `rbi_n`=0 with code 0000 → 0000000 and `rbo_n`=0.
  - Code 0101 with `rbi_n`=0 → 1011011 and `rbo_n`=1.
  - `rbi_n`=1 with code 0000 → 1111110 and `rbo_n`=1.
- Parameter variants:
  - `SEG_ACTIVE_LOW`=1, code 1000 → 0000000.
  - Same variant in reset → 1111111.
  - `HEX_MODE`=1, codes 1010 and 1111 → 1110111 and 1000111.
- Async reset mid-stream: while code 1000 is displayed, pulse `rst_n` low between clock edges → outputs clear immediately without waiting for an edge. They recover to 1111111 one edge after `rst_n` returns high.
